// File: rtl/video_timing_gen.sv
// video_timing_gen
//   720p60 (CEA-861 by default) raster timing generator with frame-buffer pixel
//   fetch. It sits one stage upstream of an rgb2dvi encoder. A pixel request
//   is issued REQ_LEAD cycles before the matching active pixel appears on the
//   vid_p* outputs. The returned pixel is re-aligned with registered
//   VSync/HSync/DE. Black is substituted when a fetch arrives late, and the
//   fetched data can be replaced with internal colour bars.
//
// Ports
//   PixelClk       in   pixel clock
//   aRst           in   asynchronous reset, active-high
//   en_i           in   timing enable; only acted on at a frame boundary
//   pattern_sel_i  in   1 = colour bars, 0 = fetched pixel data
//   pix_req_o      out  request one pixel (raster order), combinational
//   frame_start_o  out  pulse with the first pix_req_o of each frame
//   pix_data_i     in   fetched pixel {R,G,B}
//   pix_valid_i    in   pix_data_i valid, sampled REQ_LEAD-1 cycles after request
//   vid_pVSync     out  VSync, high-valid, registered
//   vid_pHSync     out  HSync, high-valid, registered
//   vid_pVDE       out  active video, registered
//   vid_pData      out  {R[23:16],G[15:8],B[7:0]}, registered
//   underflow_o    out  sticky: some DE pixel of this frame lacked pix_valid_i
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int REQ_LEAD = 2
) (
  input  logic        PixelClk,
  input  logic        aRst,
  input  logic        en_i,
  input  logic        pattern_sel_i,
  output logic        pix_req_o,
  output logic        frame_start_o,
  input  logic [23:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        vid_pVSync,
  output logic        vid_pHSync,
  output logic        vid_pVDE,
  output logic [23:0] vid_pData,
  output logic        underflow_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [HW-1:0]   h_cnt_r;
  logic [VW-1:0]   v_cnt_r;

  logic            de_raw_s;
  logic            hs_raw_s;
  logic            vs_raw_s;

  // Timing delay line, bit 2 = de, bit 1 = hs, bit 0 = vs.
  logic [2:0]      tim_r [REQ_LEAD];

  // DE and x position one stage before the outputs: this is what the data
  // register sees at the edge where the upstream pixel is sampled.
  logic            pre_de_s;
  logic [HW-1:0]   pre_x_s;

  logic [23:0]     data_nxt_s;
  logic            ufl_evt_s;
  logic [23:0]     data_r;
  logic            ufl_r;

  // Bar index is x / BAR_W, built from threshold compares instead of a divider.
  function automatic logic [23:0] bar_colour(input logic [HW-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x) >= k * BAR_W) begin
        idx = 3'(k);
      end else begin
        idx = idx;
      end
    end
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Run/idle state and raster counters; a running frame always finishes.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      state_r <= ST_IDLE;
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          h_cnt_r <= '0;
          v_cnt_r <= '0;
          if (en_i) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (h_cnt_r == H_LAST) begin
            h_cnt_r <= '0;
            if (v_cnt_r == V_LAST) begin
              v_cnt_r <= '0;
              state_r <= en_i ? ST_RUN : ST_IDLE;
            end else begin
              v_cnt_r <= v_cnt_r + VW'(1);
            end
          end else begin
            h_cnt_r <= h_cnt_r + HW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          h_cnt_r <= '0;
          v_cnt_r <= '0;
        end
      endcase
    end
  end

  // Raw timing decoded from the counters; idle counters sit at 0, so gate on RUN.
  always_comb begin
    de_raw_s = 1'b0;
    hs_raw_s = 1'b0;
    vs_raw_s = 1'b0;
    if (state_r == ST_RUN) begin
      de_raw_s = (h_cnt_r < H_ACT_L) && (v_cnt_r < V_ACT_L);
      hs_raw_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
      vs_raw_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    end else begin
      de_raw_s = 1'b0;
      hs_raw_s = 1'b0;
      vs_raw_s = 1'b0;
    end
  end

  assign pix_req_o     = de_raw_s;
  assign frame_start_o = de_raw_s && (h_cnt_r == '0) && (v_cnt_r == '0);

  // REQ_LEAD-stage delay of de/hs/vs towards the encoder.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      for (int i = 0; i < REQ_LEAD; i++) begin
        tim_r[i] <= 3'b000;
      end
    end else begin
      tim_r[0] <= {de_raw_s, hs_raw_s, vs_raw_s};
      for (int i = 1; i < REQ_LEAD; i++) begin
        tim_r[i] <= tim_r[i-1];
      end
    end
  end

  generate
    if (REQ_LEAD == 1) begin : g_pre_direct
      assign pre_de_s = de_raw_s;
      assign pre_x_s  = h_cnt_r;
    end else begin : g_pre_delayed
      logic [HW-1:0] x_r [REQ_LEAD-1];

      // x position delayed alongside DE, only as far as the data register needs.
      always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
          for (int i = 0; i < REQ_LEAD - 1; i++) begin
            x_r[i] <= '0;
          end
        end else begin
          x_r[0] <= h_cnt_r;
          for (int i = 1; i < REQ_LEAD - 1; i++) begin
            x_r[i] <= x_r[i-1];
          end
        end
      end

      assign pre_de_s = tim_r[REQ_LEAD-2][2];
      assign pre_x_s  = x_r[REQ_LEAD-2];
    end
  endgenerate

  // Pixel source select: blank, colour bars, fetched data, or black on underflow.
  always_comb begin
    data_nxt_s = 24'h000000;
    ufl_evt_s  = 1'b0;
    if (!pre_de_s) begin
      data_nxt_s = 24'h000000;
    end else if (pattern_sel_i) begin
      data_nxt_s = bar_colour(pre_x_s);
    end else if (pix_valid_i) begin
      data_nxt_s = pix_data_i;
    end else begin
      data_nxt_s = 24'h000000;
      ufl_evt_s  = 1'b1;
    end
  end

  // Output pixel register and sticky underflow; a new underflow beats the frame clear.
  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      data_r <= 24'h000000;
      ufl_r  <= 1'b0;
    end else begin
      data_r <= data_nxt_s;
      if (ufl_evt_s) begin
        ufl_r <= 1'b1;
      end else if (frame_start_o) begin
        ufl_r <= 1'b0;
      end else begin
        ufl_r <= ufl_r;
      end
    end
  end

  assign vid_pVDE    = tim_r[REQ_LEAD-1][2];
  assign vid_pHSync  = tim_r[REQ_LEAD-1][1];
  assign vid_pVSync  = tim_r[REQ_LEAD-1][0];
  assign vid_pData   = data_r;
  assign underflow_o = ufl_r;

endmodule
